skolem_sweep_ctrl: RTL

- Sequencer and checker for a combinational Skolem-function datapath solving the bvuge/bvmul invertibility condition: find x such that (x*s) mod 2^W >=u t.
- Exhaustively drives every (s,t) pair into the Skolem datapath and waits a fixed settle latency before sampling x.
- Checks each result against the invertibility-condition predicate, counts failures and records the first failing vector.
- Sits beside a synthesized Skolem netlist in the verification harness; start/done handshake to the host.

---
 rtl/skolem_sweep_ctrl_pkg.sv | 19 +
 rtl/skolem_sweep_ctrl_if.sv | 28 ++
 rtl/skolem_sweep_ctrl_check.sv | 21 ++
 rtl/skolem_sweep_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/skolem_sweep_ctrl_pkg.sv
// Shared types and constants for the Skolem sweep controller.
package skolem_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int DEF_W   = 4;
    localparam int DEF_LAT = 1;

    // Number of (s,t) vectors in an exhaustive sweep of width w.
    function automatic int vec_count(input int w);
        return 1 << (2 * w);
    endfunction

endpackage

// File: rtl/skolem_sweep_ctrl_if.sv
// Host handshake, result and datapath operand signals of the sweep controller.
interface skolem_sweep_ctrl_if
    import skolem_sweep_pkg::*;
#(
    parameter int W = DEF_W
);
    logic           start;
    logic           busy;
    logic           done;
    logic           pass;
    logic [2*W:0]   fail_cnt;
    logic [W-1:0]   fail_s;
    logic [W-1:0]   fail_t;
    logic [W-1:0]   fail_x;
    logic [W-1:0]   sk_s;
    logic [W-1:0]   sk_t;
    logic [W-1:0]   sk_x;

    modport master (
        input  start, sk_x,
        output busy, done, pass, fail_cnt, fail_s, fail_t, fail_x, sk_s, sk_t
    );

    modport slave (
        output start, sk_x,
        input  busy, done, pass, fail_cnt, fail_s, fail_t, fail_x, sk_s, sk_t
    );
endinterface

// File: rtl/skolem_sweep_ctrl_check.sv
// Invertibility-condition checker for (x*s) mod 2^W >=u t; swap this module for other operator pairs.
module bvmul_uge_ic_check #(
    parameter int W = 4
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [W-1:0] x,
    output logic         ok
);
    logic [W-1:0] prod;
    logic [W-1:0] neg_s;
    logic [W-1:0] ic_bound;
    logic         ic;

    assign prod     = x * s;
    assign neg_s    = -s;
    // (-s | s) is the largest multiple of s reachable modulo 2^W.
    assign ic_bound = neg_s | s;
    assign ic       = (t <= ic_bound);
    assign ok       = !ic || (prod >= t);
endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive (s,t) sweep driver and checker for a Skolem datapath.
// Optional macro SKOLEM_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module skolem_sweep_ctrl
    import skolem_sweep_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int LAT = DEF_LAT
) (
    input  logic                clk,
    input  logic                rst,
    skolem_sweep_ctrl_if.master bus
);
    localparam int             CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((LAT > 0) ? (LAT - 1) : 0);
    localparam logic [2*W-1:0] V_LAST   = (2*W)'(vec_count(W) - 1);
    localparam state_t         VEC_ST   = (LAT == 0) ? CHECK : SETTLE;

    state_t         state_q;
    logic [2*W-1:0] v_q;
    logic [2*W-1:0] v_inc;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic           pass_q;
    logic [2*W:0]   fail_cnt_q;
    logic [W-1:0]   fail_s_q;
    logic [W-1:0]   fail_t_q;
    logic [W-1:0]   fail_x_q;
    logic [W-1:0]   sk_s_q;
    logic [W-1:0]   sk_t_q;
    logic           ok;
    logic           last_vec;
    logic           stop_now;

    bvmul_uge_ic_check #(.W(W)) u_check (
        .s  (sk_s_q),
        .t  (sk_t_q),
        .x  (bus.sk_x),
        .ok (ok)
    );

    assign v_inc    = v_q + 1'b1;
    assign last_vec = (v_q == V_LAST);
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = last_vec || !ok;
`else
    assign stop_now = last_vec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            v_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            fail_s_q   <= '0;
            fail_t_q   <= '0;
            fail_x_q   <= '0;
            sk_s_q     <= '0;
            sk_t_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        v_q        <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        fail_cnt_q <= '0;
                        fail_s_q   <= '0;
                        fail_t_q   <= '0;
                        fail_x_q   <= '0;
                        sk_s_q     <= '0;
                        sk_t_q     <= '0;
                        state_q    <= VEC_ST;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (!ok) begin
                        fail_cnt_q <= fail_cnt_q + 1'b1;
                        if (fail_cnt_q == '0) begin
                            fail_s_q <= sk_s_q;
                            fail_t_q <= sk_t_q;
                            fail_x_q <= bus.sk_x;
                        end
                    end
                    if (stop_now) begin
                        state_q <= DONE;
                    end else begin
                        v_q     <= v_inc;
                        sk_s_q  <= v_inc[W-1:0];
                        sk_t_q  <= v_inc[2*W-1:W];
                        cnt_q   <= '0;
                        state_q <= VEC_ST;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (fail_cnt_q == '0);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.fail_s   = fail_s_q;
    assign bus.fail_t   = fail_t_q;
    assign bus.fail_x   = fail_x_q;
    assign bus.sk_s     = sk_s_q;
    assign bus.sk_t     = sk_t_q;
endmodule
